// File: rtl/hex8_disp_arb.sv
// Round-robin arbiter sharing one hex8 seven-segment display between four sources.
// Each grant holds the display for a fixed dwell slot, then rotates, extends, or idles.
module hex8_disp_arb #(
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter bit          BLANK_IDLE   = 1'b1
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [3:0]   req_i,
  input  logic [127:0] req_data_i,
  output logic [3:0]   grant_o,
  output logic [3:0]   ack_o,
  output logic         busy_o,
  output logic         disp_en_o,
  output logic [31:0]  disp_data_o
);

  localparam int NUM_SRC = 4;
  localparam int CNT_W   = $clog2(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL_CYCLES - 1);

  typedef enum logic {IDLE, SHOW} state_e;

  state_e                   state_q, state_d;
  logic [1:0]               ptr_q, ptr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [NUM_SRC-1:0]       grant_q, grant_d;
  logic [NUM_SRC-1:0]       ack_q, ack_d;
  logic                     busy_q, busy_d;
  logic                     en_q, en_d;
  logic [31:0]              data_q, data_d;

  logic [NUM_SRC-1:0][31:0] word;
  logic                     oth_vld;
  logic [1:0]               oth_idx;
  logic                     take;
  logic [1:0]               take_idx;

  assign word = req_data_i;

  // Nearest requester after ptr, excluding ptr itself; scanning backwards lets
  // the closest one overwrite the farther ones.
  always_comb begin
    oth_vld = 1'b0;
    oth_idx = ptr_q;
    for (int k = NUM_SRC - 1; k >= 1; k--) begin
      if (req_i[ptr_q + 2'(k)]) begin
        oth_vld = 1'b1;
        oth_idx = ptr_q + 2'(k);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    ack_d    = '0;
    busy_d   = busy_q;
    en_d     = en_q;
    data_d   = data_q;
    take     = 1'b0;
    take_idx = oth_idx;

    unique case (state_q)
      IDLE: begin
        if (oth_vld || req_i[ptr_q]) begin
          take     = 1'b1;
          take_idx = oth_vld ? oth_idx : ptr_q;
        end
      end
      SHOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
          if (req_i[ptr_q]) data_d = word[ptr_q];
        end else if (oth_vld) begin
          take = 1'b1;
        end else if (req_i[ptr_q]) begin
          cnt_d  = RELOAD;
          data_d = word[ptr_q];
        end else begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          en_d    = ~BLANK_IDLE;
        end
      end
      default: ;
    endcase

    // New slot: shared by the IDLE grant and the direct SHOW->SHOW switch.
    if (take) begin
      state_d = SHOW;
      ptr_d   = take_idx;
      cnt_d   = RELOAD;
      grant_d = NUM_SRC'(1) << take_idx;
      ack_d   = NUM_SRC'(1) << take_idx;
      busy_d  = 1'b1;
      en_d    = 1'b1;
      data_d  = word[take_idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      cnt_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      data_q  <= data_d;
    end
  end

  assign grant_o     = grant_q;
  assign ack_o       = ack_q;
  assign busy_o      = busy_q;
  assign disp_en_o   = en_q;
  assign disp_data_o = data_q;

endmodule
